outport_seg7_driver: RTL and testbench

- Display stage directly downstream of the processor datapath's 32-bit output port register.
- Consumes the OutPort_out word and drives a multiplexed, active-low, 8-digit seven-segment hex display.
- Filters bus-transition glitches with a stability qualifier, latches the qualified word, and scans digits with a prescaled refresh counter.
- Supports optional leading-zero blanking.

---
 rtl/seg7_pkg.sv | 37 +++
 rtl/hex_to_seg7.sv | 33 +++
 rtl/outport_seg7_driver.sv | 129 ++++++++++++
 tb/tb_outport_seg7_driver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: active-low
// gfedcba patterns for each hex digit, the blank pattern, and a
// constant-evaluable ceil(log2) used to size counters.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] HEX7_0 = 7'h40;
    localparam logic [6:0] HEX7_1 = 7'h79;
    localparam logic [6:0] HEX7_2 = 7'h24;
    localparam logic [6:0] HEX7_3 = 7'h30;
    localparam logic [6:0] HEX7_4 = 7'h19;
    localparam logic [6:0] HEX7_5 = 7'h12;
    localparam logic [6:0] HEX7_6 = 7'h02;
    localparam logic [6:0] HEX7_7 = 7'h78;
    localparam logic [6:0] HEX7_8 = 7'h00;
    localparam logic [6:0] HEX7_9 = 7'h10;
    localparam logic [6:0] HEX7_A = 7'h08;
    localparam logic [6:0] HEX7_B = 7'h03;
    localparam logic [6:0] HEX7_C = 7'h46;
    localparam logic [6:0] HEX7_D = 7'h21;
    localparam logic [6:0] HEX7_E = 7'h06;
    localparam logic [6:0] HEX7_F = 7'h0E;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-segment decoder, active-low {g,f,e,d,c,b,a}.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Straight table lookup of the hex glyph for the selected nibble.
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = HEX7_0;
            4'h1: seg = HEX7_1;
            4'h2: seg = HEX7_2;
            4'h3: seg = HEX7_3;
            4'h4: seg = HEX7_4;
            4'h5: seg = HEX7_5;
            4'h6: seg = HEX7_6;
            4'h7: seg = HEX7_7;
            4'h8: seg = HEX7_8;
            4'h9: seg = HEX7_9;
            4'hA: seg = HEX7_A;
            4'hB: seg = HEX7_B;
            4'hC: seg = HEX7_C;
            4'hD: seg = HEX7_D;
            4'hE: seg = HEX7_E;
            4'hF: seg = HEX7_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/outport_seg7_driver.sv
// Display stage behind the datapath output port: qualifies the incoming
// word for stability, latches it into shown, and scans it onto a
// multiplexed active-low hex display with optional leading-zero blanking.
module outport_seg7_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 8,
    parameter int SCAN_DIV      = 50000,
    parameter int STABLE_CYCLES = 4,
    parameter int BLANK_LZ      = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [31:0]       data_in,
    input  logic              enable,
    output logic [DIGITS-1:0] an,
    output logic [6:0]        seg,
    output logic [31:0]       shown,
    output logic              updated
);

    localparam int CNT_W = (clog2(STABLE_CYCLES) > 0) ? clog2(STABLE_CYCLES) : 1;
    localparam int PSC_W = (clog2(SCAN_DIV) > 0) ? clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (clog2(DIGITS) > 0) ? clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [31:0]       cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       shown_q, shown_d;
    logic              updated_q, updated_d;
    logic [PSC_W-1:0]  psc_q, psc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic [31:0]       shifted;
    logic [3:0]        nibble;
    logic [6:0]        hex_seg;
    logic              blank_digit;

    // Stability qualifier: a new word restarts the count; once it has held
    // long enough it is latched, pulsing updated only if it differs.
    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        shown_d   = shown_q;
        updated_d = 1'b0;
        if (data_in != cand_q) begin
            cand_d = data_in;
            cnt_d  = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end else if (cand_q != shown_q) begin
            shown_d   = cand_q;
            updated_d = 1'b1;
        end
    end

    // Refresh prescaler and digit index; both park at zero while disabled
    // so re-enabling always starts the scan at digit 0.
    always_comb begin
        psc_d = psc_q;
        idx_d = idx_q;
        if (!enable) begin
            psc_d = '0;
            idx_d = '0;
        end else if (psc_q == PSC_LAST) begin
            psc_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end else begin
            psc_d = psc_q + 1'b1;
        end
    end

    // Select the current digit; shifted==0 means this nibble and every
    // higher one are zero, which is exactly the leading-zero condition.
    always_comb begin
        shifted     = shown_q >> {idx_q, 2'b00};
        nibble      = shifted[3:0];
        blank_digit = (BLANK_LZ != 0) && (idx_q != '0) && (shifted == 32'h0);
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    // Next anode/segment values, registered so the pins never glitch.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_BLANK;
        if (enable) begin
            an_d  = ~(DIGITS'(1) << idx_q);
            seg_d = blank_digit ? SEG_BLANK : hex_seg;
        end
    end

    // All state, with synchronous active-low clear taking priority.
    always_ff @(posedge clk) begin
        if (!clr) begin
            cand_q    <= '0;
            cnt_q     <= '0;
            shown_q   <= '0;
            updated_q <= 1'b0;
            psc_q     <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            shown_q   <= shown_d;
            updated_q <= updated_d;
            psc_q     <= psc_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign shown   = shown_q;
    assign updated = updated_q;

endmodule

// File: tb/tb_outport_seg7_driver.sv
// Directed bench for outport_seg7_driver: one instance without and one
// with leading-zero blanking, both with a fast scan (SCAN_DIV=4).
module tb_outport_seg7_driver;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] data_in;
    logic        enable;

    logic [7:0]  an_0, an_1;
    logic [6:0]  seg_0, seg_1;
    logic [31:0] shown_0, shown_1;
    logic        updated_0, updated_1;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    logic seen_glitch = 1'b0;

    logic [29:0] exp_q[$];
    logic [6:0]  seg_a[8];
    logic [6:0]  seg_b[8];

    // Clock and instances
    always #5 clk = ~clk;

    outport_seg7_driver #(
        .DIGITS(8), .SCAN_DIV(4), .STABLE_CYCLES(4), .BLANK_LZ(0)
    ) dut0 (
        .clk(clk), .clr(clr), .data_in(data_in), .enable(enable),
        .an(an_0), .seg(seg_0), .shown(shown_0), .updated(updated_0)
    );

    outport_seg7_driver #(
        .DIGITS(8), .SCAN_DIV(4), .STABLE_CYCLES(4), .BLANK_LZ(1)
    ) dut1 (
        .clk(clk), .clr(clr), .data_in(data_in), .enable(enable),
        .an(an_1), .seg(seg_1), .shown(shown_1), .updated(updated_1)
    );

    // Driver: advance one edge, sample 1 ns later, track pulses/glitches.
    task automatic tick();
        @(posedge clk);
        #1;
        if (updated_0) upd_cnt++;
        if (shown_0 == 32'h12345678 || shown_1 == 32'h12345678) seen_glitch = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expected {an0,seg0,an1,seg1} for reps consecutive cycles.
    task automatic push_digit(input int k, input logic [6:0] s0, input logic [6:0] s1, input int reps);
        logic [7:0] a;
        a = ~(8'h01 << k);
        for (int i = 0; i < reps; i++) exp_q.push_back({a, s0, a, s1});
    endtask

    task automatic drain_each_cycle(input string tag);
        logic [29:0] e;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            chk(tag, {2'b00, an_0, seg_0, an_1, seg_1}, {2'b00, e});
        end
    endtask

    // Only the first cycle of each digit is compared; digits last 4 cycles.
    task automatic drain_per_digit(input string tag);
        logic [29:0] e;
        tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, {2'b00, an_0, seg_0, an_1, seg_1}, {2'b00, e});
            ticks(4);
        end
    endtask

    initial begin
        // Reset with a word and enable present
        clr = 1'b0; data_in = 32'hDEADBEEF; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_an",      {24'h0, an_0},  32'hFF);
            chk("rst_an_lz",   {24'h0, an_1},  32'hFF);
            chk("rst_seg",     {25'h0, seg_0}, 32'h7F);
            chk("rst_shown",   shown_0,        32'h0);
            chk("rst_updated", {31'h0, updated_0}, 32'h0);
        end

        // Release: word qualifies at e0+4 (fifth edge after release)
        clr = 1'b1;
        upd_cnt = 0;
        ticks(4);
        chk("rel_shown_early", shown_0, 32'h0);
        tick();
        chk("rel_shown",   shown_0, 32'hDEADBEEF);
        chk("rel_shown_lz", shown_1, 32'hDEADBEEF);
        chk("rel_updated", {31'h0, updated_0}, 32'h1);
        tick();
        chk("rel_updated_low", {31'h0, updated_0}, 32'h0);

        // Glitch filter: short-lived word never reaches shown
        enable = 1'b0;
        data_in = 32'h12345678;
        ticks(2);
        data_in = 32'h0000ABCD;
        upd_cnt = 0;
        ticks(4);
        chk("glitch_not_yet", shown_0, 32'hDEADBEEF);
        tick();
        chk("glitch_shown", shown_0, 32'h0000ABCD);
        chk("glitch_upd_now", {31'h0, updated_0}, 32'h1);
        ticks(4);
        chk("glitch_upd_count", upd_cnt, 1);
        chk("glitch_never_shown", {31'h0, seen_glitch}, 32'h0);

        // Scan and decode of 89ABCDEF, four cycles per digit, then wrap
        data_in = 32'h89ABCDEF;
        ticks(6);
        chk("scan_shown", shown_0, 32'h89ABCDEF);
        seg_a = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        enable = 1'b1;
        for (int k = 0; k < 8; k++) push_digit(k, seg_a[k], seg_a[k], 4);
        push_digit(0, seg_a[0], seg_a[0], 4);
        drain_each_cycle("scan");

        // Disable mid-scan, then re-enable restarts at digit 0
        enable = 1'b0;
        tick();
        chk("dis_an",  {16'h0, an_0, an_1},  32'hFFFF);
        chk("dis_seg", {18'h0, seg_0, seg_1}, 32'h3FFF);
        tick();
        chk("dis_an_hold", {24'h0, an_0}, 32'hFF);
        enable = 1'b1;
        push_digit(0, seg_a[0], seg_a[0], 4);
        push_digit(1, seg_a[1], seg_a[1], 4);
        drain_each_cycle("reenable");

        // Leading-zero blanking of 00000A05
        enable = 1'b0;
        data_in = 32'h00000A05;
        ticks(6);
        chk("lz_shown", shown_1, 32'h00000A05);
        seg_a = '{7'h12, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        seg_b = '{7'h12, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        enable = 1'b1;
        for (int k = 0; k < 8; k++) push_digit(k, seg_a[k], seg_b[k], 1);
        drain_per_digit("lz_a05");

        // Value zero: blanking keeps only digit 0
        enable = 1'b0;
        data_in = 32'h0;
        ticks(6);
        chk("zero_shown", shown_0, 32'h0);
        enable = 1'b1;
        for (int k = 0; k < 8; k++) push_digit(k, 7'h40, (k == 0) ? 7'h40 : 7'h7F, 1);
        drain_per_digit("lz_zero");

        // Re-driving the shown word never pulses updated
        enable = 1'b0;
        upd_cnt = 0;
        data_in = 32'h00000001;
        tick();
        data_in = 32'h0;
        ticks(8);
        chk("same_no_pulse", upd_cnt, 0);
        chk("same_shown", shown_0, 32'h0);

        // Reset while digit 5 is lit and qualification is at cnt=2
        tick();
        enable = 1'b1;
        ticks(18);
        data_in = 32'hCAFE0123;
        ticks(3);
        chk("mid_an_idx5", {24'h0, an_0}, 32'hDF);
        clr = 1'b0;
        tick();
        chk("mid_rst_an",  {16'h0, an_0, an_1},  32'hFFFF);
        chk("mid_rst_seg", {18'h0, seg_0, seg_1}, 32'h3FFF);
        chk("mid_rst_shown", shown_0, 32'h0);
        chk("mid_rst_upd", {31'h0, updated_0}, 32'h0);
        tick();
        chk("mid_rst_pending", shown_0, 32'h0);
        clr = 1'b1;
        tick();
        chk("mid_post_an", {24'h0, an_0}, 32'hFE);
        ticks(3);
        chk("mid_post_wait", shown_0, 32'h0);
        tick();
        chk("mid_post_shown", shown_0, 32'hCAFE0123);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
